uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the number of clk cycles per bit (100 MHz / 115200 baud); legal range 4 or more.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the receive FIFO entry count; it SHALL be a power of 2, minimum 2.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 rxd  input  1  SHALL be the asynchronous serial line, 8N1 format, idle high.
REQ-006 rd_en  input  1  SHALL be a one-cycle pop request from the peripheral bus.
REQ-007 clr_err  input  1  SHALL clear the sticky error flags.
REQ-008 rd_data  output  8  SHALL show the FIFO head byte (show-ahead).
REQ-009 rx_valid  output  1  SHALL be high when the FIFO is not empty.
REQ-010 level  output  $clog2(FIFO_DEPTH)+1  SHALL give the current FIFO occupancy.
REQ-011 overrun  output  1  SHALL be a sticky flag meaning a byte was dropped because the FIFO was full.
REQ-012 frame_err  output  1  SHALL be a sticky flag meaning a stop bit was sampled as 0.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 IDLE to START SHALL occur when the synchronized rxd is low.
REQ-016 In START, at count CLKS_PER_BIT/2-1:
- rxd low: go to DATA and clear the counter.
- rxd high: go back to IDLE as a false start.
REQ-017 In DATA, 8 bits SHALL be sampled LSB first, each at count CLKS_PER_BIT-1 measured from the previous sample point; the FSM then goes to STOP.
REQ-018 In STOP, the stop bit SHALL be sampled at count CLKS_PER_BIT-1.
- The push into the FIFO SHALL happen on the following clock edge.
- The FSM SHALL then return to IDLE immediately, without waiting out the rest of the stop bit.
REQ-019 A pushed byte SHALL appear on rd_data/rx_valid on the cycle after the push if the FIFO was empty; there is no extra latency.
REQ-020 rd_en with rx_valid high SHALL advance the head by one entry; rd_en while empty SHALL be ignored, with no pointer change.
REQ-021 Push while full and no pop in the same cycle: the byte SHALL be dropped, overrun SHALL be set, and FIFO contents SHALL be unchanged.
REQ-022 Push and pop in the same cycle while full SHALL both succeed; level stays FIFO_DEPTH and overrun is not set.
REQ-023 Push and pop in the same cycle while empty SHALL perform only the push; the pop is ignored.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be computed from pointers one bit wider than the address.
REQ-025 clr_err SHALL clear both flags on the next edge; if a flag is set in the same cycle, the set SHALL win.

Reset
REQ-026 Asserting reset_n low SHALL immediately force:
- FSM to IDLE
- counters, bit index and pointers to 0
- rd_data = 0x00, rx_valid = 0, level = 0, overrun = 0, frame_err = 0
- synchronizer flops to 1
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release, reception SHALL restart only on a fresh falling edge of rxd.

Configuration
REQ-028 With UART_RX_FRAME_ERR_EN defined, a stop bit sampled as 0 SHALL set frame_err and discard the byte (no push).
REQ-029 With UART_RX_FRAME_ERR_EN undefined, the stop bit value SHALL be ignored, every byte SHALL be pushed, and frame_err SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state enum (IDLE, START, DATA, STOP)
- the constants UART_DEFAULT_CLKS_PER_BIT = 868 and UART_DEFAULT_FIFO_DEPTH = 4
REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo_sa (show-ahead, parameterised width and depth); the receiver FSM stays in uart_rx_fifo.

Verification
REQ-032 The bench SHALL run with CLKS_PER_BIT=16 and FIFO_DEPTH=4. Required scenarios:
- Send 0xA5 -> rx_valid rises about 9.5 bit times after the start edge; rd_data = 0xA5; level = 1; pulse rd_en -> rx_valid = 0, level = 0.
- Low glitch on rxd for 5 cycles -> FSM returns to IDLE; no push; level = 0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 without reading -> level = 4, overrun = 1, pops give 0x01 to 0x04 in order; pulse clr_err -> overrun = 0.
- FIFO full, assert rd_en exactly on the push cycle of a 5th byte 0x55 -> overrun = 0, level = 4, last entry = 0x55.
- Stop bit forced 0 on byte 0x3C -> with the macro: frame_err = 1, level = 0; without the macro: frame_err = 0, rd_data = 0x3C.
- Drop reset_n in the middle of data bit 4 of 0xFF, release, then send 0x81 -> only 0x81 received, level = 1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver with its receive FIFO.
// Receiver FSM state encoding and default build parameters.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int UART_DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: the head entry is always visible on o_data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo_sa
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // A pop on an empty FIFO is ignored, so a simultaneous push only writes.
  assign w_do_pop  = i_pop && !w_empty;
  // When full, the push fits only because the same-cycle pop frees a slot.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_drop    = i_push && w_full && !i_pop;
  assign o_valid   = !w_empty;
  assign o_level   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO.
// Optional build macro UART_RX_FRAME_ERR_EN: when defined, a zero stop bit sets
// frame_err and the byte is discarded; when undefined every byte is pushed and
// frame_err stays 0.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]     r_sync;
  logic           w_rxd_s;
  uart_rx_state_e r_state, w_state_d;
  logic [CW-1:0]  r_cnt, w_cnt_d;
  logic [2:0]     r_bit, w_bit_d;
  logic [7:0]     r_shift, w_shift_d;
  logic           r_push, w_push_d;
  logic           w_ferr_set;
  logic           w_drop;

  assign w_rxd_s = r_sync[1];

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], rxd};
  end

  // Receiver next-state: sample at mid-bit, LSB first, push after the stop bit.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt + 1'b1;
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_push_d   = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_d = '0;
        w_bit_d = '0;
        if (!w_rxd_s) w_state_d = START;
      end
      START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_d   = '0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_d = w_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_d   = '0;
          w_shift_d = {w_rxd_s, r_shift[7:1]};
          w_bit_d   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_d = STOP;
        end
      end
      STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_d   = '0;
          // Return early so a back-to-back start bit is not missed.
          w_state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          w_push_d   = w_rxd_s;
          w_ferr_set = !w_rxd_s;
`else
          w_push_d   = 1'b1;
`endif
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_push  <= w_push_d;
    end
  end

  sync_fifo_sa #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (r_push),
    .i_data  (r_shift),
    .i_pop   (rd_en),
    .o_data  (rd_data),
    .o_valid (rx_valid),
    .o_level (level),
    .o_drop  (w_drop)
  );

  // Sticky overrun flag; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overrun <= 1'b0;
    else if (w_drop)  overrun <= 1'b1;
    else if (clr_err) overrun <= 1'b0;
  end

`ifdef UART_RX_FRAME_ERR_EN
  // Sticky frame error flag; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        frame_err <= 1'b0;
    else if (w_ferr_set) frame_err <= 1'b1;
    else if (clr_err)    frame_err <= 1'b0;
  end
`else
  assign frame_err = 1'b0;
  logic w_unused;
  assign w_unused = w_ferr_set;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed UART frames, received bytes checked by a
// scoreboard queue that a monitor drains on every accepted pop.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] level;
  logic       overrun;
  logic       frame_err;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .level     (level),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Called on a negedge; drives one 8N1 frame with the given stop bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: just before each rising edge, an accepted pop must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rd_en && rx_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
        end else begin
          check("pop_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_level", level, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte and its latency from the start edge.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        cyc = 0;
        while (!rx_valid && cyc < 300) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    check("a5_latency_in_range", (cyc >= 150 && cyc <= 160), 1);
    check("a5_rd_data", rd_data, 8'hA5);
    check("a5_level", level, 1);
    pop();
    check("a5_rx_valid_after_pop", rx_valid, 0);
    check("a5_level_after_pop", level, 0);

    // Short low glitch is a false start.
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_level", level, 0);
    check("glitch_rx_valid", rx_valid, 0);

    // Overflow: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    check("ovf_level", level, 4);
    check("ovf_overrun", overrun, 1);
    check("ovf_head", rd_data, 8'h01);
    for (int i = 0; i < 4; i++) pop();
    check("ovf_drained_level", level, 0);
    check("ovf_overrun_held", overrun, 1);
    pulse_clr();
    check("ovf_overrun_cleared", overrun, 0);

    // Full FIFO with a pop on the exact push cycle.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("full_level", level, 4);
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1);
      begin
        // The FIFO write lands on the 156th rising edge after the start bit.
        repeat (155) @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check("simul_overrun", overrun, 0);
    check("simul_level", level, 4);
    check("simul_head", rd_data, 8'h22);
    for (int i = 0; i < 4; i++) pop();
    check("simul_drained_level", level, 0);

    // Stop bit sampled as zero.
`ifdef UART_RX_FRAME_ERR_EN
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_flag", frame_err, 1);
    check("ferr_level", level, 0);
    pulse_clr();
    check("ferr_cleared", frame_err, 0);
`else
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_flag_tied", frame_err, 0);
    check("ferr_rd_data", rd_data, 8'h3C);
    check("ferr_level", level, 1);
    pop();
`endif
    repeat (20) @(negedge clk);
    check("ferr_end_level", level, 0);

    // Reset in the middle of data bit 4.
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (CPB * 5 + 8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("midrst_level", level, 1);
    check("midrst_rd_data_81", rd_data, 8'h81);
    pop();
    check("midrst_final_level", level, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
